// File: rtl/apb_rr_master.sv
// APB master shared by NUM_REQ requesters through a round-robin arbiter.
// Runs the SETUP/ACCESS sequence and aborts an ACCESS that stalls past TIMEOUT cycles.
module apb_rr_master #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr,
  output logic [1:0]                dbg_state
);

  localparam int RR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  // Handshake: a requester holds req_valid and payload until its one-cycle
  // req_grant pulse; completion is a one-cycle rsp_valid pulse carrying
  // rsp_rdata/rsp_err. The APB side uses plain psel/penable/pready.
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [RR_W-1:0]     rr_q, rr_d;
  logic [RR_W-1:0]     sel_q, sel_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d, rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                pick_found;
  logic [RR_W-1:0]     pick_idx;

  // First requesting index at or after rr_q, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && req_valid[(int'(rr_q) + i) % NUM_REQ]) begin
        pick_found = 1'b1;
        pick_idx   = RR_W'((int'(rr_q) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    sel_d       = sel_q;
    wait_d      = wait_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    grant_d     = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        pwrite_d  = 1'b0;
        if (pick_found) begin
          sel_d    = pick_idx;
          grant_d  = NUM_REQ'(1) << pick_idx;
          paddr_d  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          pwdata_d = req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
          pwrite_d = req_write[pick_idx];
          psel_d   = 1'b1;
          rr_d     = (pick_idx == RR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        wait_d    = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          pwrite_d    = 1'b0;
          rsp_valid_d = NUM_REQ'(1) << sel_q;
          rsp_err_d   = pslverr;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          state_d     = IDLE;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          // Slave never answered: release the bus and report an error.
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          pwrite_d    = 1'b0;
          rsp_valid_d = NUM_REQ'(1) << sel_q;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      sel_q       <= '0;
      wait_q      <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      sel_q       <= sel_d;
      wait_q      <= wait_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_grant = grant_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign dbg_state = state_q;

endmodule
